// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: the serial pins toward the SPI master plus the
// byte-level transmit/receive handshake toward the local host logic.
interface spi_slave_if;
  // serial side
  logic       sck;
  logic       cs;
  logic       mosi;
  logic       miso;
  // host transmit side
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  // host receive side and status
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       tx_underrun;

  // view from inside the slave block
  modport slave (
    input  sck, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );

  // view from the surrounding environment (SPI master + host)
  modport master (
    output sck, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by the system clock.
// sck/cs/mosi are resynchronized into clk and edge-detected; a one-byte
// holding register feeds the transmit shifter at every byte boundary, and
// DEFAULT_TX is sent (with a tx_underrun pulse) when the host had nothing
// queued. Received bytes are reported with a one-cycle rx_valid pulse.
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizer output becomes meaningful once every stage plus the
  // history flop has captured a real post-reset sample.
  localparam logic [2:0] FILL_CYCLES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sck_hist_reg;
  logic                   cs_hist_reg;
  logic [2:0]             fill_cnt_reg;

  logic       sck_s;
  logic       cs_s;
  logic       mosi_s;
  logic       fill_done;
  logic       sck_rise;
  logic       sck_fall;
  logic       cs_fall;
  logic       cs_rise;

  state_t     state_reg;
  logic       busy_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_out_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       frame_err_reg;
  logic       tx_underrun_reg;

  logic       hold_full_reg;
  logic [7:0] hold_data_reg;

  logic       tx_accept;
  logic       load_evt;
  logic [7:0] rx_byte_next;

  // Input synchronizers plus history flops; reset to the bus idle levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sck_hist_reg  <= 1'b0;
      cs_hist_reg   <= 1'b1;
      fill_cnt_reg  <= 3'd0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], bus.sck};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.mosi};
      sck_hist_reg  <= sck_sync_reg[SYNC_STAGES-1];
      cs_hist_reg   <= cs_sync_reg[SYNC_STAGES-1];
      if (fill_cnt_reg != FILL_CYCLES) begin
        fill_cnt_reg <= fill_cnt_reg + 3'd1;
      end
    end
  end

  assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign fill_done = (fill_cnt_reg == FILL_CYCLES);

  // Edge strobes. Until the pipeline has refilled after reset the history
  // flop still holds its reset value, so a cs held low across reset would
  // look like a falling edge; gating with fill_done makes the block wait
  // for a genuine cs falling edge instead.
  always_comb begin
    sck_rise = fill_done &  sck_s & ~sck_hist_reg;
    sck_fall = fill_done & ~sck_s &  sck_hist_reg;
    cs_fall  = fill_done & ~cs_s  &  cs_hist_reg;
    cs_rise  = fill_done &  cs_s  & ~cs_hist_reg;
  end

  // Byte-load points: frame start, and each byte boundary that is not
  // pre-empted by cs going high in the same cycle.
  always_comb begin
    load_evt = 1'b0;
    if (state_reg == IDLE) begin
      load_evt = cs_fall;
    end else if (!cs_rise && sck_fall && (bit_cnt_reg == 4'd8)) begin
      load_evt = 1'b1;
    end
  end

  assign tx_accept    = bus.tx_valid & ~hold_full_reg;
  assign rx_byte_next = {rx_shift_reg[6:0], mosi_s};

  // Holding register: a write in the same cycle as a consume wins, so the
  // new byte stays queued while the old one goes to the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= 8'h00;
    end else if (tx_accept) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= bus.tx_data;
    end else if (load_evt) begin
      hold_full_reg <= 1'b0;
    end
  end

  // Frame FSM with shifters, counters and all registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      busy_reg        <= 1'b0;
      bit_cnt_reg     <= 4'd0;
      shift_out_reg   <= 8'h00;
      rx_shift_reg    <= 8'h00;
      rx_data_reg     <= 8'h00;
      rx_valid_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      tx_underrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg       <= SHIFT;
            busy_reg        <= 1'b1;
            bit_cnt_reg     <= 4'd0;
            shift_out_reg   <= hold_full_reg ? hold_data_reg : DEFAULT_TX;
            tx_underrun_reg <= ~hold_full_reg;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // End of frame; a partially shifted byte is dropped and flagged.
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            bit_cnt_reg   <= 4'd0;
            shift_out_reg <= 8'h00;
            if ((bit_cnt_reg != 4'd0) && (bit_cnt_reg != 4'd8)) begin
              frame_err_reg <= 1'b1;
            end
          end else if (sck_rise) begin
            if (bit_cnt_reg != 4'd8) begin
              rx_shift_reg <= rx_byte_next;
              bit_cnt_reg  <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                rx_data_reg  <= rx_byte_next;
                rx_valid_reg <= 1'b1;
              end
            end
          end else if (sck_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              bit_cnt_reg     <= 4'd0;
              shift_out_reg   <= hold_full_reg ? hold_data_reg : DEFAULT_TX;
              tx_underrun_reg <= ~hold_full_reg;
            end else if (bit_cnt_reg != 4'd0) begin
              shift_out_reg <= {shift_out_reg[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miso        = busy_reg & shift_out_reg[7];
  assign bus.tx_ready    = ~hold_full_reg;
  assign bus.rx_data     = rx_data_reg;
  assign bus.rx_valid    = rx_valid_reg;
  assign bus.busy        = busy_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a transaction-level
// model (holding register, expected byte queues, expected pulse counts).
module tb_spi_slave;
  localparam logic [7:0] DEF = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_if bus ();

  spi_slave #(.DEFAULT_TX(DEF), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic       model_full = 1'b0;
  logic [7:0] model_hold = 8'h00;
  logic [7:0] model_rx_last = 8'h00;
  logic [7:0] exp_rx_q[$];
  int exp_uf = 0, seen_uf = 0;
  int exp_fe = 0, seen_fe = 0;
  int seen_rx = 0;
  logic prev_rx_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One byte-load: holding byte if queued, otherwise the default + underrun.
  function automatic logic [7:0] model_load();
    if (model_full) begin
      model_full = 1'b0;
      return model_hold;
    end
    exp_uf++;
    return DEF;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        seen_rx++;
        check("rx_valid_width", 32'(prev_rx_valid), 32'd0);
        if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'(bus.rx_valid), 32'd0);
        else model_rx_last = exp_rx_q.pop_front();
      end
      check("rx_data", 32'(bus.rx_data), 32'(model_rx_last));
      if (!bus.busy) check("miso_idle", 32'(bus.miso), 32'd0);
      if (bus.frame_err) seen_fe++;
      if (bus.tx_underrun) seen_uf++;
      prev_rx_valid = bus.rx_valid;
    end
  end

  task automatic push_tx(input logic [7:0] v);
    check("tx_ready_model", 32'(bus.tx_ready), 32'(!model_full));
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_hold = v;
    end
    check("tx_ready_after_push", 32'(bus.tx_ready), 32'd0);
  endtask

  // Master frame of nbits (MSB first from mo[nbits-1]); a full-byte frame
  // drops sck and raises cs together after the last rising edge.
  task automatic spi_frame(input int nbits, input logic [31:0] mo, input int push_byte,
                           input logic [7:0] push_val, output logic [31:0] mi);
    logic [7:0] exp_cur;
    logic [7:0] got;
    int full;
    full = nbits / 8;
    mi = '0;
    got = '0;
    exp_cur = '0;
    for (int k = 0; k < full; k++) exp_rx_q.push_back(8'(mo >> (nbits - 8 * (k + 1))));
    if ((nbits % 8) != 0) exp_fe++;
    bus.cs = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[nbits - 1 - i];
      if ((i % 8) == 0) exp_cur = model_load();
      if ((i / 8) == push_byte && (i % 8) == 2) begin
        push_tx(push_val);
        tick(3);
      end else begin
        tick(4);
      end
      check("busy_in_frame", 32'(bus.busy), 32'd1);
      got = {got[6:0], bus.miso};
      mi  = {mi[30:0], bus.miso};
      bus.sck = 1'b1;
      tick(4);
      if ((i % 8) == 7) check("master_rx_byte", 32'(got), 32'(exp_cur));
      bus.sck = 1'b0;
      if (i == nbits - 1 && (nbits % 8) == 0) bus.cs = 1'b1;
    end
    if ((nbits % 8) != 0) begin
      tick(4);
      bus.cs = 1'b1;
    end
    tick(8);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    check("frame_err_count", 32'(seen_fe), 32'(exp_fe));
    check("underrun_count", 32'(seen_uf), 32'(exp_uf));
    check("rx_pending", 32'(exp_rx_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] mi;
    int rx0, uf0, fe0, nbytes, part, nbits, pb;
    bus.sck = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_pulses", {29'd0, bus.rx_valid, bus.frame_err, bus.tx_underrun}, 32'd0);
    rst = 1'b0;
    tick(8);

    // queued A5 out, 3C in
    rx0 = seen_rx;
    push_tx(8'hA5);
    spi_frame(8, 32'h3C, -1, 8'h00, mi);
    check("t1_master_rx", 32'(mi[7:0]), 32'hA5);
    check("t1_rx_data", 32'(bus.rx_data), 32'h3C);
    check("t1_rx_pulses", 32'(seen_rx - rx0), 32'd1);
    check("t1_tx_ready", 32'(bus.tx_ready), 32'd1);

    // nothing queued -> default byte and one underrun
    uf0 = seen_uf;
    spi_frame(8, 32'h00, -1, 8'h00, mi);
    check("t2_master_rx", 32'(mi[7:0]), 32'hFF);
    check("t2_underrun", 32'(seen_uf - uf0), 32'd1);

    // two-byte frame, second byte queued during the first
    rx0 = seen_rx;
    push_tx(8'h11);
    spi_frame(16, 32'h0102, 0, 8'h22, mi);
    check("t3_master_rx", 32'(mi[15:0]), 32'h1122);
    check("t3_rx_data", 32'(bus.rx_data), 32'h02);
    check("t3_rx_pulses", 32'(seen_rx - rx0), 32'd2);

    // partial frame of 5 bits
    rx0 = seen_rx; fe0 = seen_fe;
    spi_frame(5, 32'b10110, -1, 8'h00, mi);
    check("t4_rx_pulses", 32'(seen_rx - rx0), 32'd0);
    check("t4_frame_err", 32'(seen_fe - fe0), 32'd1);
    check("t4_rx_data", 32'(bus.rx_data), 32'h02);

    // reset mid-byte with the holding register full
    push_tx(8'h99);
    bus.cs = 1'b0;
    tick(6);
    void'(model_load());
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'b1; tick(4); bus.sck = 1'b1; tick(4); bus.sck = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_miso", 32'(bus.miso), 32'd0);
    check("r_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("r_rx_data", 32'(bus.rx_data), 32'h00);
    check("r_pulses", {29'd0, bus.rx_valid, bus.frame_err, bus.tx_underrun}, 32'd0);
    model_full = 1'b0;
    model_rx_last = 8'h00;
    exp_rx_q.delete();
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(4); bus.sck = 1'b1; tick(4); bus.sck = 1'b0;
      check("r_busy_ignored", 32'(bus.busy), 32'd0);
    end
    tick(4);
    bus.cs = 1'b1;
    tick(8);
    check("r_no_frame_err", 32'(seen_fe), 32'(exp_fe));
    spi_frame(8, 32'h5C, -1, 8'h00, mi);
    check("r_master_rx", 32'(mi[7:0]), 32'hFF);
    check("r_rx_data", 32'(bus.rx_data), 32'h5C);

    // tx_valid held while not ready: only the byte at the ready edge sticks
    push_tx(8'h5A);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h77;
    tick(5);
    check("h_tx_ready_low", 32'(bus.tx_ready), 32'd0);
    bus.tx_data = 8'hC3;
    spi_frame(8, 32'hE1, -1, 8'h00, mi);
    bus.tx_valid = 1'b0;
    check("h_master_rx", 32'(mi[7:0]), 32'h5A);
    check("h_tx_ready_full", 32'(bus.tx_ready), 32'd0);
    model_full = 1'b1;
    model_hold = 8'hC3;
    spi_frame(8, 32'h0F, -1, 8'h00, mi);
    check("h_master_rx2", 32'(mi[7:0]), 32'hC3);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      nbytes = int'($urandom_range(1, 3));
      part   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      nbits  = nbytes * 8 + part;
      if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
      pb = int'($urandom_range(0, nbytes)) - 1;
      spi_frame(nbits, $urandom, pb, 8'($urandom), mi);
      tick(int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DEFAULT_TX, default 8'hFF, byte shifted out when no transmit byte is queued at a byte boundary.
REQ-002 Parameter SYNC_STAGES, default 2, depth of the input synchronizers on sck, cs and mosi (legal 2..3).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sck  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-006 cs  input  1  SPI chip select, active low.
REQ-007 mosi  input  1  SPI data from master, MSB first.
REQ-008 miso  output  1  SPI data to master, MSB first.
REQ-009 tx_data  input  8  byte to transmit in the next frame byte.
REQ-010 tx_valid  input  1  tx_data valid; transfer occurs when tx_valid and tx_ready are both high on a clk edge.
REQ-011 tx_ready  output  1  holding register empty.
REQ-012 rx_data  output  8  last complete received byte.
REQ-013 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-014 busy  output  1  high while in SHIFT state.
REQ-015 frame_err  output  1  one-cycle pulse: cs deasserted with a partial byte.
REQ-016 tx_underrun  output  1  one-cycle pulse: DEFAULT_TX loaded because holding register was empty.

Function
REQ-017 sck, cs, mosi SHALL each pass through SYNC_STAGES flops plus one history flop; edges are detected by comparing the last synchronizer stage to the history flop.
REQ-018 Correct operation SHALL be guaranteed for sck period >= 8 clk periods and cs-falling-to-first-sck-rise >= 4 clk periods.
REQ-019 States: IDLE, SHIFT; IDLE -> SHIFT on detected cs falling edge; SHIFT -> IDLE on detected cs rising edge; no other transitions.
REQ-020 On IDLE -> SHIFT: bit counter := 0; shift-out register loaded from holding register if full (holding emptied), else DEFAULT_TX with tx_underrun pulse in the same cycle.
REQ-021 miso SHALL equal shift-out register bit 7 while in SHIFT, and 0 in IDLE.
REQ-022 Detected sck rising edge in SHIFT: synchronized mosi (same delay as sck) shifted into receive register LSB; bit counter += 1.
REQ-023 Detected sck falling edge in SHIFT with bit counter 1..7: shift-out register shifts left by one, zero fill.
REQ-024 Detected sck falling edge with bit counter 8: counter := 0; shift-out register reloaded per REQ-020 rule (holding or DEFAULT_TX + tx_underrun).
REQ-025 On the 8th rising edge of a byte: rx_data := completed byte, rx_valid high for exactly the next clk cycle; no backpressure, a new byte overwrites rx_data.
REQ-026 tx_ready SHALL deassert the cycle after an accepted transfer and reassert the cycle after the holding register is consumed; a transfer and a consume in the same cycle SHALL leave the holding register full with the new byte.
REQ-027 tx_valid while tx_ready low SHALL be ignored; tx_data accepted in any state.
REQ-028 cs rising edge with bit counter 1..7: partial byte discarded, no rx_valid, frame_err pulse one cycle; the loaded transmit byte is discarded, holding register untouched.
REQ-029 cs rising edge with bit counter 0 or 8: no frame_err; if counter 8, rx_valid per REQ-025 still issued.
REQ-030 sck edges while in IDLE SHALL be ignored.
REQ-031 busy SHALL be high exactly while in SHIFT.

Reset
REQ-032 rst high SHALL immediately force: state IDLE, miso 0, tx_ready 1, holding empty, rx_data 8'h00, rx_valid 0, busy 0, frame_err 0, tx_underrun 0, bit counter 0, synchronizers to idle levels (sck 0, cs 1, mosi 0).
REQ-033 rst asserted mid-frame SHALL abort the frame without frame_err; after release the block waits for a fresh cs falling edge.

Verification
REQ-034 Queue tx 8'hA5, master sends 8'h3C with sck = clk/8 -> master receives 8'hA5; rx_data = 8'h3C with one rx_valid pulse; tx_ready high again after cs fall.
REQ-035 No tx queued, master sends 8'h00 -> master receives 8'hFF; tx_underrun pulses once at cs fall.
REQ-036 Queue 8'h11, cs low for two bytes 8'h01, 8'h02, queue 8'h22 during byte 1 -> master receives 8'h11, 8'h22; two rx_valid pulses with 8'h01 then 8'h02.
REQ-037 cs raised after 5 sck cycles -> no rx_valid, one frame_err pulse, rx_data unchanged, busy low after detected cs rise.
REQ-038 rst pulsed mid-byte with holding register full -> all outputs at reset values, tx_ready 1, no frame_err; next full frame works with DEFAULT_TX.
REQ-039 tx_valid held high with new data while tx_ready low -> data ignored until tx_ready rises; byte present at that edge is accepted.
